// File: rtl/dvi_tmds_pkg.sv
// Shared TMDS constants and helpers for the DVI encoder: control codes, disparity width, popcount.
package dvi_tmds_pkg;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   localparam int CNT_W = 5;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: transition-minimising stage followed by the DC-balancing stage.
// TMDS_OUTPUT_REG_EN adds a ce-gated output register after the balancing stage.
module tmds_channel_encoder
   import dvi_tmds_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic       de,
   input  logic [1:0] c,
   input  logic [7:0] d,
   output logic [9:0] sym
);

   function automatic logic [8:0] minimise_transitions(input logic [7:0] din);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] m;
      n1       = popcount8(din);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !din[0]);
      m        = '0;
      m[0]     = din[0];
      for (int i = 1; i < 8; i++) begin
         m[i] = use_xnor ? ~(m[i-1] ^ din[i]) : (m[i-1] ^ din[i]);
      end
      m[8] = ~use_xnor;
      return m;
   endfunction

   logic [8:0]              qm_q;
   logic                    de_q;
   logic [1:0]              c_q;
   logic [9:0]              sym_q;
   logic signed [CNT_W-1:0] cnt;

   logic [3:0]              n1q;
   logic signed [CNT_W:0]   diff;
   logic signed [CNT_W:0]   cnt_ext;
   logic signed [CNT_W:0]   two_q8;
   logic signed [CNT_W:0]   two_nq8;
   logic signed [CNT_W:0]   cnt_next;
   logic [9:0]              sym_next;
   logic                    cnt_pos;
   logic                    cnt_neg;
   logic                    diff_pos;
   logic                    diff_neg;

   // diff is n1q - n0q, i.e. 2*n1q - 8; one extra bit keeps the sums exact before truncation
   always_comb begin
      n1q      = popcount8(qm_q[7:0]);
      diff     = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
      cnt_ext  = {cnt[CNT_W-1], cnt};
      two_q8   = qm_q[8] ? 6'sd2 : 6'sd0;
      two_nq8  = qm_q[8] ? 6'sd0 : 6'sd2;
      cnt_pos  = !cnt[CNT_W-1] && (cnt != '0);
      cnt_neg  = cnt[CNT_W-1];
      diff_pos = !diff[CNT_W] && (diff != '0);
      diff_neg = diff[CNT_W];
      sym_next = CTRL_00;
      cnt_next = '0;
      if (!de_q) begin
         case (c_q)
            2'b00:   sym_next = CTRL_00;
            2'b01:   sym_next = CTRL_01;
            2'b10:   sym_next = CTRL_10;
            default: sym_next = CTRL_11;
         endcase
      end else if ((cnt == '0) || (diff == '0)) begin
         sym_next = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
         cnt_next = qm_q[8] ? (cnt_ext + diff) : (cnt_ext - diff);
      end else if ((cnt_pos && diff_pos) || (cnt_neg && diff_neg)) begin
         sym_next = {1'b1, qm_q[8], ~qm_q[7:0]};
         cnt_next = cnt_ext + two_q8 - diff;
      end else begin
         sym_next = {1'b0, qm_q[8], qm_q[7:0]};
         cnt_next = cnt_ext - two_nq8 + diff;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qm_q  <= '0;
         de_q  <= 1'b0;
         c_q   <= '0;
         sym_q <= CTRL_00;
         cnt   <= '0;
      end else if (ce) begin
         qm_q  <= minimise_transitions(d);
         de_q  <= de;
         c_q   <= c;
         sym_q <= sym_next;
         cnt   <= cnt_next[CNT_W-1:0];
      end
   end

`ifdef TMDS_OUTPUT_REG_EN
   logic [9:0] sym_out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_out_q <= CTRL_00;
      end else if (ce) begin
         sym_out_q <= sym_q;
      end
   end

   assign sym = sym_out_q;
`else
   assign sym = sym_q;
`endif

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder front end: three channel encoders plus the output-valid tracker.
// TMDS_OUTPUT_REG_EN adds one output stage (latency 3 instead of 2 ce cycles).
module dvi_tmds_encoder
   import dvi_tmds_pkg::*;
#(
   parameter int w_color = 8
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ce,
   input  logic               de,
   input  logic               hsync,
   input  logic               vsync,
   input  logic [w_color-1:0] red,
   input  logic [w_color-1:0] green,
   input  logic [w_color-1:0] blue,
   output logic [9:0]         tmds_r,
   output logic [9:0]         tmds_g,
   output logic [9:0]         tmds_b,
   output logic               tmds_valid
);

   if (w_color != 8) begin : g_bad_width
      $error("dvi_tmds_encoder: w_color must be 8");
   end

`ifdef TMDS_OUTPUT_REG_EN
   localparam int LATENCY = 3;
`else
   localparam int LATENCY = 2;
`endif

   logic [LATENCY-1:0] valid_sr;

   tmds_channel_encoder u_red (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .de    (de),
      .c     (2'b00),
      .d     (red),
      .sym   (tmds_r)
   );

   tmds_channel_encoder u_green (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .de    (de),
      .c     (2'b00),
      .d     (green),
      .sym   (tmds_g)
   );

   tmds_channel_encoder u_blue (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .de    (de),
      .c     ({vsync, hsync}),
      .d     (blue),
      .sym   (tmds_b)
   );

   // A one fills the shift register once per ce, so valid rises exactly when the first sample emerges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_sr <= '0;
      end else if (ce) begin
         valid_sr <= {valid_sr[LATENCY-2:0], 1'b1};
      end
   end

   assign tmds_valid = valid_sr[LATENCY-1];

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Scoreboard bench for dvi_tmds_encoder: stimulus pushes expected symbols, a monitor pops and compares.
module tb_dvi_tmds_encoder;

   localparam logic [9:0] C00 = 10'b1101010100;
   localparam logic [9:0] C01 = 10'b0010101011;
   localparam logic [9:0] C10 = 10'b0101010100;
   localparam logic [9:0] C11 = 10'b1010101011;

`ifdef TMDS_OUTPUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ce = 1'b0;
   logic       de = 1'b0;
   logic       hsync = 1'b0;
   logic       vsync = 1'b0;
   logic [7:0] red = '0;
   logic [7:0] green = '0;
   logic [7:0] blue = '0;
   logic [9:0] tmds_r;
   logic [9:0] tmds_g;
   logic [9:0] tmds_b;
   logic       tmds_valid;

   int          checks = 0;
   int          passes = 0;
   logic [29:0] exp_q[$];
   int          cnt_r = 0;
   int          cnt_g = 0;
   int          cnt_b = 0;
   logic [29:0] last_exp = '0;
   bit          have_last = 1'b0;

   always #5 clk = ~clk;

   dvi_tmds_encoder #(.w_color(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .de         (de),
      .hsync      (hsync),
      .vsync      (vsync),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .tmds_r     (tmds_r),
      .tmds_g     (tmds_g),
      .tmds_b     (tmds_b),
      .tmds_valid (tmds_valid)
   );

   // Reference encoder written from the DVI 1.0 algorithm with plain integer disparity
   function automatic logic [9:0] model_encode(input logic de_i, input logic [1:0] c_i,
                                               input logic [7:0] d_i, inout int cnt_io);
      logic [8:0] qm;
      int         n1, n1q, n0q, q8;
      logic [9:0] s;
      n1 = $countones(d_i);
      qm = '0;
      qm[0] = d_i[0];
      if (n1 > 4 || (n1 == 4 && d_i[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d_i[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d_i[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      q8  = qm[8] ? 1 : 0;
      if (!de_i) begin
         case (c_i)
            2'b00:   s = C00;
            2'b01:   s = C01;
            2'b10:   s = C10;
            default: s = C11;
         endcase
         cnt_io = 0;
      end else if (cnt_io == 0 || n1q == n0q) begin
         s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cnt_io = cnt_io + (q8 == 1 ? (n1q - n0q) : (n0q - n1q));
      end else if ((cnt_io > 0 && n1q > n0q) || (cnt_io < 0 && n0q > n1q)) begin
         s = {1'b1, qm[8], ~qm[7:0]};
         cnt_io = cnt_io + 2 * q8 + n0q - n1q;
      end else begin
         s = {1'b0, qm[8], qm[7:0]};
         cnt_io = cnt_io - 2 * (1 - q8) + n1q - n0q;
      end
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
   endtask

   task automatic applyStimulus(input logic ce_i, input logic de_i, input logic hs_i, input logic vs_i,
                                input logic [7:0] r_i, input logic [7:0] g_i, input logic [7:0] b_i,
                                input logic hand, input logic [9:0] hr, input logic [9:0] hg,
                                input logic [9:0] hb);
      logic [9:0] mr, mg, mb;
      @(negedge clk);
      ce = ce_i; de = de_i; hsync = hs_i; vsync = vs_i;
      red = r_i; green = g_i; blue = b_i;
      if (ce_i) begin
         mr = model_encode(de_i, 2'b00, r_i, cnt_r);
         mg = model_encode(de_i, 2'b00, g_i, cnt_g);
         mb = model_encode(de_i, {vs_i, hs_i}, b_i, cnt_b);
         if (hand) exp_q.push_back({hr, hg, hb});
         else exp_q.push_back({mr, mg, mb});
      end
   endtask

   // Monitor: one symbol leaves the pipeline per ce edge once valid; without ce the outputs must hold
   always @(posedge clk) begin
      logic        ce_s;
      logic [29:0] e;
      ce_s = ce;
      #1;
      if (!rst_n) begin
         have_last = 1'b0;
      end else if (tmds_valid) begin
         if (ce_s) begin
            checkOutput("queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("tmds_r", {22'd0, tmds_r}, {22'd0, e[29:20]});
               checkOutput("tmds_g", {22'd0, tmds_g}, {22'd0, e[19:10]});
               checkOutput("tmds_b", {22'd0, tmds_b}, {22'd0, e[9:0]});
               last_exp  = e;
               have_last = 1'b1;
            end
            checkOutput("cnt_range_r", {31'd0, ($signed(dut.u_red.cnt) >= -10) && ($signed(dut.u_red.cnt) <= 10)}, 32'd1);
            checkOutput("cnt_range_g", {31'd0, ($signed(dut.u_green.cnt) >= -10) && ($signed(dut.u_green.cnt) <= 10)}, 32'd1);
            checkOutput("cnt_range_b", {31'd0, ($signed(dut.u_blue.cnt) >= -10) && ($signed(dut.u_blue.cnt) <= 10)}, 32'd1);
         end else if (have_last) begin
            checkOutput("hold_r", {22'd0, tmds_r}, {22'd0, last_exp[29:20]});
            checkOutput("hold_g", {22'd0, tmds_g}, {22'd0, last_exp[19:10]});
            checkOutput("hold_b", {22'd0, tmds_b}, {22'd0, last_exp[9:0]});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [9:0] codes [4];
      codes[0] = C00; codes[1] = C01; codes[2] = C10; codes[3] = C11;

      repeat (3) @(negedge clk);
      checkOutput("reset_r", {22'd0, tmds_r}, {22'd0, C00});
      checkOutput("reset_g", {22'd0, tmds_g}, {22'd0, C00});
      checkOutput("reset_b", {22'd0, tmds_b}, {22'd0, C00});
      checkOutput("reset_valid", {31'd0, tmds_valid}, 32'd0);
      rst_n = 1'b1;

      for (int k = 1; k <= LAT; k++) begin
         applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, C00, C00, C00);
         @(posedge clk); #1;
         checkOutput("valid_ramp", {31'd0, tmds_valid}, {31'd0, k == LAT});
      end

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, i[0], i[1], 8'h00, 8'h00, 8'h00, 1, C00, C00, codes[i]);
      end
      applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, C00, C00, C00);

      applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);
      applyStimulus(0, 1, 0, 0, 8'h5A, 8'hA5, 8'h3C, 0, '0, '0, '0);
      applyStimulus(0, 1, 0, 0, 8'h5A, 8'hA5, 8'h3C, 0, '0, '0, '0);
      applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h3FF, 10'h3FF, 10'h3FF);
      applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, C00, C00, C00);
      applyStimulus(1, 1, 0, 0, 8'hFF, 8'h00, 8'h00, 1, 10'h200, 10'h100, 10'h100);
      applyStimulus(1, 1, 0, 0, 8'hFF, 8'h00, 8'h00, 1, 10'h0FF, 10'h3FF, 10'h3FF);

      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 0, '0, '0, '0);
      end

      applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, '0, '0, '0);
      applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, '0, '0, '0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      ce = 1'b0;
      #1;
      checkOutput("midreset_r", {22'd0, tmds_r}, {22'd0, C00});
      checkOutput("midreset_g", {22'd0, tmds_g}, {22'd0, C00});
      checkOutput("midreset_b", {22'd0, tmds_b}, {22'd0, C00});
      checkOutput("midreset_valid", {31'd0, tmds_valid}, 32'd0);
      exp_q.delete();
      cnt_r = 0; cnt_g = 0; cnt_b = 0;
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);
      for (int i = 0; i < LAT + 2; i++) begin
         applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, C00, C00, C00);
      end
      @(posedge clk); #2;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
